// File: rtl/conv_pkg.sv
// Shared types for the convolution filter scheduler: FSM states and the
// result-buffer entry carried from the core return path to the output port.
package conv_pkg;

  // Entry fields are sized for the widest supported build; narrower builds
  // sign-/zero-extend on push and truncate on pop.
  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_FILT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_FILT_W-1:0] filt;
    logic                    last;
  } result_entry_t;

endpackage

// File: rtl/conv_result_fifo.sv
// First-word-fall-through result buffer; pop_data shows the head entry
// whenever the buffer is non-empty. DEPTH must be a power of 2.
module conv_result_fifo
  import conv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  result_entry_t push_data,
  input  logic          pop,
  output result_entry_t pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  result_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; its contents are only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/conv_filter_scheduler.sv
// Steps the shared 3x3 core through NUM_FILTERS filters per window and streams
// the results downstream. Define CONV_SCHED_RELU_EN to clamp negative results to 0.
module conv_filter_scheduler
  import conv_pkg::*;
#(
  parameter  int NUM_FILTERS  = 8,
  parameter  int RESULT_WIDTH = 24,
  parameter  int FIFO_DEPTH   = 4,
  localparam int FILT_W       = $clog2(NUM_FILTERS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           win_valid,
  output logic                           win_ready,
  output logic        [FILT_W-1:0]       filt_idx,
  output logic                           core_valid_in,
  input  logic signed [RESULT_WIDTH-1:0] core_result,
  input  logic                           core_valid_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [RESULT_WIDTH-1:0] out_data,
  output logic        [FILT_W-1:0]       out_filt,
  output logic                           out_last,
  output logic                           busy,
  output logic                           err_unexpected
);

  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FILT_W-1:0] LAST_IDX = FILT_W'(NUM_FILTERS - 1);

  sched_state_e                   state_q, state_d;
  logic          [FILT_W-1:0]     issue_idx_q, issue_idx_d;
  logic          [FILT_W-1:0]     ret_idx_q, ret_idx_d;
  logic          [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                           err_q, err_d;
  logic                           busy_q, busy_d;

  logic          [CNT_W-1:0]      fifo_count, fifo_count_next;
  logic          [CNT_W:0]        credit_sum;
  logic                           fifo_full, fifo_empty;
  logic                           issue, last_issue, ret_ok, push_ok, pop;
  logic signed   [RESULT_WIDTH-1:0] push_result;
  result_entry_t                  push_entry, head_entry;
  logic                           unused_head;

  always_comb begin
    // Credit uses registered counts only; a same-cycle pop is not counted.
    credit_sum = {1'b0, fifo_count} + {1'b0, outstanding_q};
    issue      = (state_q == RUN) && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
    last_issue = issue && (issue_idx_q == LAST_IDX);
    // A return with nothing outstanding is flagged and otherwise ignored.
    ret_ok     = core_valid_out && (outstanding_q != '0);
    push_ok    = ret_ok && !fifo_full;
    pop        = !fifo_empty && out_ready;

`ifdef CONV_SCHED_RELU_EN
    push_result = core_result[RESULT_WIDTH-1] ? '0 : core_result;
`else
    push_result = core_result;
`endif
    push_entry.data = ENTRY_DATA_W'(push_result);
    push_entry.filt = ENTRY_FILT_W'(ret_idx_q);
    push_entry.last = (ret_idx_q == LAST_IDX);

    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = RUN;
          issue_idx_d = '0;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_d     = IDLE;
          issue_idx_d = '0;
        end else if (issue) begin
          issue_idx_d = issue_idx_q + FILT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    outstanding_d = outstanding_q;
    case ({issue, ret_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    ret_idx_d = ret_idx_q;
    if (ret_ok) begin
      ret_idx_d = (ret_idx_q == LAST_IDX) ? '0 : ret_idx_q + FILT_W'(1);
    end

    fifo_count_next = fifo_count;
    if (push_ok && !pop) begin
      fifo_count_next = fifo_count + CNT_W'(1);
    end else if (!push_ok && pop) begin
      fifo_count_next = fifo_count - CNT_W'(1);
    end

    err_d  = err_q || (core_valid_out && (outstanding_q == '0));
    busy_d = (state_d != IDLE) || (outstanding_d != '0) || (fifo_count_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_idx_q   <= '0;
      ret_idx_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_idx_q   <= issue_idx_d;
      ret_idx_q     <= ret_idx_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  conv_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ok),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head_entry),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Entry fields are wider than this build needs; the spare bits are dropped.
  assign unused_head = ^head_entry;

  assign core_valid_in  = issue;
  assign win_ready      = last_issue;
  assign filt_idx       = issue_idx_q;
  assign out_valid      = !fifo_empty;
  assign out_data       = out_valid ? RESULT_WIDTH'(head_entry.data) : '0;
  assign out_filt       = out_valid ? FILT_W'(head_entry.filt) : '0;
  assign out_last       = out_valid && head_entry.last;
  assign busy           = busy_q;
  assign err_unexpected = err_q;

endmodule
